// File: rtl/mannix_mem_read_arb.sv
// mannix_mem_read_arb: read-port arbiter and burst sequencer for the mannix
// memory farm. Masked-priority then round-robin selection, grant locked for a
// whole burst, one address per accepted beat, in-order data routed back to the
// burst owner.
// Optional build macro: MANNIX_ARB_STARVE_EN adds per-client wait counters,
// a starvation override in arbitration and the starve_flag output.

`ifdef MANNIX_ARB_STARVE_EN
// Per-client wait counter; saturates at 255, which marks the client starving.
module mannix_arb_starve_lane (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic starving
);
    logic [7:0] wait_cnt;

    // count cycles spent requesting without being granted
    always_ff @(posedge clk) begin
        if (rst)                           wait_cnt <= '0;
        else if (gnt)                      wait_cnt <= '0;
        else if (req && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end

    assign starving = req && (wait_cnt == 8'hFF);
endmodule
`endif

module mannix_mem_read_arb #(
    parameter int NUM_CLIENTS     = 5,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int LEN_W           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLIENTS-1:0]        client_priority,
    input  logic [NUM_CLIENTS-1:0]        cl_req,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [NUM_CLIENTS*LEN_W-1:0]  cl_len,
    output logic [NUM_CLIENTS-1:0]        cl_gnt,
    output logic [NUM_CLIENTS-1:0]        cl_rvalid,
    output logic                          cl_rlast,
    output logic [DATA_W-1:0]             cl_rdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy
`ifdef MANNIX_ARB_STARVE_EN
    ,
    output logic                          starve_flag
`endif
);
    localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                                 state, state_nxt;
    logic [NUM_CLIENTS-1:0][ADDR_W-1:0]     addr_arr;
    logic [NUM_CLIENTS-1:0][LEN_W-1:0]      len_arr;
    logic [NUM_CLIENTS-1:0]                 hi_req, elig, gnt_nxt;
    logic [CW-1:0]                          rr_ptr, owner, win, cand;
    logic [CW:0]                            sum;
    logic                                   win_found;
    logic [BW-1:0]                          beats, issued, returned;
    logic [OW-1:0]                          outstanding;
    logic                                   accept, ret;

    assign addr_arr = cl_addr;
    assign len_arr  = cl_len;

`ifdef MANNIX_ARB_STARVE_EN
    logic [NUM_CLIENTS-1:0] starving;
    logic                   starve_hit;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_starve
        mannix_arb_starve_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .req      (cl_req[g]),
            .gnt      (gnt_nxt[g]),
            .starving (starving[g])
        );
    end
`endif

    // winner select: high-priority class if any, then first at/after rr_ptr
    always_comb begin
        hi_req    = cl_req & client_priority;
        elig      = (hi_req != '0) ? hi_req : cl_req;
        win       = '0;
        win_found = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            sum = {1'b0, rr_ptr} + (CW+1)'(k);
            if (sum >= (CW+1)'(NUM_CLIENTS)) sum = sum - (CW+1)'(NUM_CLIENTS);
            cand = sum[CW-1:0];
            if (!win_found && elig[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
`ifdef MANNIX_ARB_STARVE_EN
        // a starving client beats both mask and rotation; lowest index first
        starve_hit = 1'b0;
        if (starving != '0) begin
            for (int k = NUM_CLIENTS - 1; k >= 0; k--)
                if (starving[CW'(k)]) win = CW'(k);
            win_found  = 1'b1;
            starve_hit = 1'b1;
        end
`endif
    end

    // address issue is allowed only under the in-flight cap
    assign mem_req = (state == BURST) && (issued < beats) &&
                     (outstanding < OW'(MAX_OUTSTANDING));
    assign accept  = mem_req && mem_ready;
    // returns outside a burst are protocol errors and are dropped
    assign ret     = mem_rvalid && (state != IDLE);
    assign busy    = (state != IDLE);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and grant decode
    always_comb begin
        state_nxt = state;
        gnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt    = BURST;
                    gnt_nxt[win] = 1'b1;
                end
            end
            BURST: if (accept && issued == beats - 1'b1)  state_nxt = DRAIN;
            DRAIN: if (ret && returned == beats - 1'b1)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // burst datapath, counters and registered return path
    always_ff @(posedge clk) begin
        if (rst) begin
            cl_gnt      <= '0;
            cl_rvalid   <= '0;
            cl_rlast    <= 1'b0;
            cl_rdata    <= '0;
            mem_addr    <= '0;
            rr_ptr      <= '0;
            owner       <= '0;
            beats       <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
        end else begin
            cl_gnt    <= gnt_nxt;
            cl_rvalid <= '0;
            cl_rlast  <= 1'b0;
            if (state == IDLE && win_found) begin
                mem_addr <= addr_arr[win];
                beats    <= {1'b0, len_arr[win]} + 1'b1;
                owner    <= win;
                rr_ptr   <= (win == CW'(NUM_CLIENTS - 1)) ? '0 : win + 1'b1;
                issued   <= '0;
                returned <= '0;
            end
            if (accept) begin
                mem_addr <= mem_addr + 1'b1;
                issued   <= issued + 1'b1;
            end
            if (ret) begin
                cl_rvalid[owner] <= 1'b1;
                cl_rdata         <= mem_rdata;
                cl_rlast         <= (returned == beats - 1'b1);
                returned         <= returned + 1'b1;
            end
            case ({accept, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef MANNIX_ARB_STARVE_EN
    // pulse alongside a grant that came from the starvation override
    always_ff @(posedge clk) begin
        if (rst) starve_flag <= 1'b0;
        else     starve_flag <= starve_hit && (state == IDLE);
    end
`endif
endmodule

// File: tb/tb_mannix_mem_read_arb.sv
// Directed bench for mannix_mem_read_arb with a fixed-latency in-order memory.
`timescale 1ns/1ps
module tb_mannix_mem_read_arb;
    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam logic [31:0] K = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  client_priority, cl_req, cl_gnt, cl_rvalid;
    logic [N*AW-1:0] cl_addr;
    logic [N*LW-1:0] cl_len;
    logic          cl_rlast, mem_req, busy;
    logic [DW-1:0] cl_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MANNIX_ARB_STARVE_EN
    logic          starve_flag;
`endif

    mannix_mem_read_arb dut (
        .clk(clk), .rst(rst), .client_priority(client_priority),
        .cl_req(cl_req), .cl_addr(cl_addr), .cl_len(cl_len),
        .cl_gnt(cl_gnt), .cl_rvalid(cl_rvalid), .cl_rlast(cl_rlast),
        .cl_rdata(cl_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef MANNIX_ARB_STARVE_EN
        , .starve_flag(starve_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mp_t;
    mp_t         mem_pipe[$];
    mp_t         e;
    logic [31:0] acc_q[$], rv_d_q[$];
    logic [4:0]  rv_c_q[$], gnt_q[$];
    logic        rv_l_q[$];
    int cyc = 0, lat = 2, ready_cfg = 1, toggle = 0;
    int epoch = 0, seen_epoch = 0, max_inflight = 0, mem_ret_cnt = 0;
    int starve_cnt = 0;
    logic [4:0] starve_gnt = '0;
    int vectors = 0, miscompares = 0;

    always @(posedge clk) cyc++;

    // mid-cycle monitor + memory model (drives the next edge's inputs)
    always @(negedge clk) begin
        if (cl_gnt != '0) gnt_q.push_back(cl_gnt);
`ifdef MANNIX_ARB_STARVE_EN
        if (starve_flag) begin starve_cnt++; starve_gnt = cl_gnt; end
`endif
        if (cl_rvalid != '0) begin
            rv_c_q.push_back(cl_rvalid); rv_d_q.push_back(cl_rdata); rv_l_q.push_back(cl_rlast);
        end
        mem_ready = (toggle != 0) ? ~mem_ready : (ready_cfg != 0);
        if (mem_req && mem_ready) begin
            acc_q.push_back(mem_addr);
            e.addr = mem_addr; e.due = cyc + 1 + lat;
            mem_pipe.push_back(e);
        end
        mem_rvalid = 1'b0;
        if (mem_pipe.size() > 0 && mem_pipe[0].due == cyc + 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_pipe[0].addr ^ K;
            void'(mem_pipe.pop_front());
            mem_ret_cnt++;
        end
        if (epoch != seen_epoch) begin seen_epoch = epoch; max_inflight = 0; end
        if (mem_pipe.size() > max_inflight) max_inflight = mem_pipe.size();
    end

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic set_client(input int c, input logic [31:0] a, input logic [7:0] l);
        cl_addr[c*AW +: AW] = a;
        cl_len[c*LW +: LW]  = l;
    endtask

    task automatic do_reset(); rst = 1'b1; tick(); tick(); rst = 1'b0; endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cl_req = '0; repeat (3) tick();
        vectors++; if (cl_gnt !== 5'b0)    begin miscompares++; $display("FAIL reset_gnt: got %b want 00000", cl_gnt); end
        vectors++; if (cl_rvalid !== 5'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 00000", cl_rvalid); end
        vectors++; if (cl_rlast !== 1'b0)  begin miscompares++; $display("FAIL reset_rlast: got %b want 0", cl_rlast); end
        vectors++; if (cl_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", cl_rdata); end
        vectors++; if (mem_req !== 1'b0)   begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; repeat (4) tick();
        vectors++; if ({cl_gnt, mem_req, busy} !== 7'b0) begin miscompares++; $display("FAIL idle_quiet: got gnt=%b req=%b busy=%b want 0", cl_gnt, mem_req, busy); end
    endtask

    task automatic test_single();
        int ab, rb;
        set_client(2, 32'h100, 8'd3); lat = 2; ready_cfg = 1; toggle = 0;
        ab = acc_q.size(); rb = rv_d_q.size();
        cl_req = 5'b00100;
        vectors++; if (cl_gnt !== 5'b0) begin miscompares++; $display("FAIL single_gnt_early: got %b want 00000", cl_gnt); end
        tick();
        vectors++; if (cl_gnt !== 5'b00100) begin miscompares++; $display("FAIL single_gnt: got %b want 00100", cl_gnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        cl_req = '0; tick();
        vectors++; if (cl_gnt !== 5'b0) begin miscompares++; $display("FAIL single_gnt_pulse: got %b want 00000", cl_gnt); end
        wait_idle(100);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: busy=%b want 0", busy); end
        vectors++; if (acc_q.size() - ab != 4) begin miscompares++; $display("FAIL single_naddr: got %0d want 4", acc_q.size() - ab); end
        vectors++; if (rv_d_q.size() - rb != 4) begin miscompares++; $display("FAIL single_nbeats: got %0d want 4", rv_d_q.size() - rb); end
        for (int i = 0; i < 4 && ab + i < acc_q.size() && rb + i < rv_d_q.size(); i++) begin
            vectors++; if (acc_q[ab+i] !== 32'h100 + i) begin miscompares++; $display("FAIL single_addr%0d: got %h want %h", i, acc_q[ab+i], 32'h100 + i); end
            vectors++; if (rv_d_q[rb+i] !== ((32'h100 + i) ^ K)) begin miscompares++; $display("FAIL single_data%0d: got %h want %h", i, rv_d_q[rb+i], (32'h100 + i) ^ K); end
            vectors++; if (rv_c_q[rb+i] !== 5'b00100) begin miscompares++; $display("FAIL single_owner%0d: got %b want 00100", i, rv_c_q[rb+i]); end
            vectors++; if (rv_l_q[rb+i] !== (i == 3)) begin miscompares++; $display("FAIL single_last%0d: got %b want %b", i, rv_l_q[rb+i], (i == 3)); end
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] exp [6];
        int gb, n = 0;
        exp = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
        do_reset();
        cl_len = '0; set_client(0, 32'h10, 0); set_client(1, 32'h20, 0); set_client(3, 32'h30, 0);
        client_priority = '0; gb = gnt_q.size();
        cl_req = 5'b01011;
        while (gnt_q.size() - gb < 6 && n < 200) begin tick(); n++; end
        cl_req = '0; wait_idle(100);
        vectors++; if (gnt_q.size() - gb != 6) begin miscompares++; $display("FAIL rr_count: got %0d want 6", gnt_q.size() - gb); end
        for (int i = 0; i < 6 && gb + i < gnt_q.size(); i++) begin
            vectors++; if (gnt_q[gb+i] !== exp[i]) begin miscompares++; $display("FAIL rr_order%0d: got %b want %b", i, gnt_q[gb+i], exp[i]); end
        end
    endtask

    task automatic test_priority();
        logic [4:0] exp [7];
        int gb, n = 0;
        exp = '{5'b10000, 5'b10000, 5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
        do_reset();
        cl_len = '0; gb = gnt_q.size();
        client_priority = 5'b10000; cl_req = 5'b11111;
        while (gnt_q.size() - gb < 3 && n < 200) begin tick(); n++; end
        cl_req[4] = 1'b0;
        while (gnt_q.size() - gb < 7 && n < 400) begin tick(); n++; end
        cl_req = '0; client_priority = '0; wait_idle(100);
        vectors++; if (gnt_q.size() - gb != 7) begin miscompares++; $display("FAIL prio_count: got %0d want 7", gnt_q.size() - gb); end
        for (int i = 0; i < 7 && gb + i < gnt_q.size(); i++) begin
            vectors++; if (gnt_q[gb+i] !== exp[i]) begin miscompares++; $display("FAIL prio_order%0d: got %b want %b", i, gnt_q[gb+i], exp[i]); end
        end
    endtask

    task automatic test_outstanding();
        int ab, rb;
        set_client(0, 32'h2000, 8'd15); lat = 6; toggle = 1; epoch++;
        ab = acc_q.size(); rb = rv_d_q.size();
        cl_req = 5'b00001; tick(); cl_req = '0;
        wait_idle(300); toggle = 0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL os_idle: busy=%b want 0", busy); end
        vectors++; if (max_inflight > 4) begin miscompares++; $display("FAIL os_cap: got %0d in flight want <=4", max_inflight); end
        vectors++; if (rv_d_q.size() - rb != 16) begin miscompares++; $display("FAIL os_nbeats: got %0d want 16", rv_d_q.size() - rb); end
        for (int i = 0; i < 16 && ab + i < acc_q.size() && rb + i < rv_d_q.size(); i++) begin
            vectors++; if (acc_q[ab+i] !== 32'h2000 + i) begin miscompares++; $display("FAIL os_addr%0d: got %h want %h", i, acc_q[ab+i], 32'h2000 + i); end
            vectors++; if (rv_d_q[rb+i] !== ((32'h2000 + i) ^ K)) begin miscompares++; $display("FAIL os_data%0d: got %h want %h", i, rv_d_q[rb+i], (32'h2000 + i) ^ K); end
            vectors++; if (rv_l_q[rb+i] !== (i == 15)) begin miscompares++; $display("FAIL os_last%0d: got %b want %b", i, rv_l_q[rb+i], (i == 15)); end
        end
        // long latency, ready held high: the cap must be reached exactly
        set_client(0, 32'h2100, 8'd7); lat = 8; ready_cfg = 1; epoch++;
        rb = rv_d_q.size();
        cl_req = 5'b00001; tick(); cl_req = '0;
        wait_idle(300);
        vectors++; if (max_inflight != 4) begin miscompares++; $display("FAIL os_cap_full: got %0d in flight want 4", max_inflight); end
        vectors++; if (rv_d_q.size() - rb != 8) begin miscompares++; $display("FAIL os_nbeats8: got %0d want 8", rv_d_q.size() - rb); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        int ab, rb;
        exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        set_client(3, 32'hFFFF_FFFE, 8'd3); lat = 2; ready_cfg = 1;
        ab = acc_q.size(); rb = rv_d_q.size();
        cl_req = 5'b01000; tick(); cl_req = '0;
        wait_idle(100);
        vectors++; if (acc_q.size() - ab != 4) begin miscompares++; $display("FAIL wrap_naddr: got %0d want 4", acc_q.size() - ab); end
        for (int i = 0; i < 4 && ab + i < acc_q.size(); i++) begin
            vectors++; if (acc_q[ab+i] !== exp[i]) begin miscompares++; $display("FAIL wrap_addr%0d: got %h want %h", i, acc_q[ab+i], exp[i]); end
        end
        vectors++; if (rv_d_q.size() - rb != 4 || rv_d_q[rb+2] !== 32'h5A5A_0000) begin miscompares++; $display("FAIL wrap_data2: got %0d beats want 4 with beat2=5a5a0000", rv_d_q.size() - rb); end
    endtask

    task automatic test_reset_mid();
        int ab, rb, mb, n = 0;
        set_client(0, 32'h3000, 8'd7); lat = 4; ready_cfg = 1;
        ab = acc_q.size();
        cl_req = 5'b00001; tick(); cl_req = '0;
        while (acc_q.size() - ab < 2 && n < 20) begin tick(); n++; end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy: got %b want 1", busy); end
        rst = 1'b1; tick(); rst = 1'b0;
        mb = mem_ret_cnt; rb = rv_d_q.size();
        vectors++; if ({cl_gnt, cl_rvalid, cl_rlast, mem_req, busy} !== 13'b0) begin miscompares++; $display("FAIL rmid_ctrl: got gnt=%b rv=%b last=%b req=%b busy=%b want 0", cl_gnt, cl_rvalid, cl_rlast, mem_req, busy); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_addr: got %h want 0", mem_addr); end
        vectors++; if (cl_rdata !== 32'h0) begin miscompares++; $display("FAIL rmid_rdata: got %h want 0", cl_rdata); end
        repeat (15) tick();
        vectors++; if (mem_ret_cnt - mb < 1) begin miscompares++; $display("FAIL rmid_late: got %0d late returns want >=1", mem_ret_cnt - mb); end
        vectors++; if (rv_d_q.size() - rb != 0) begin miscompares++; $display("FAIL rmid_drop: got %0d cl_rvalid want 0", rv_d_q.size() - rb); end
    endtask

`ifdef MANNIX_ARB_STARVE_EN
    task automatic test_starve();
        int t0, n = 0, sb;
        logic found = 1'b0;
        do_reset();
        cl_len = '0; lat = 2; sb = starve_cnt;
        client_priority = 5'b00001; cl_req = 5'b00011; t0 = cyc;
        while (!found && n < 700) begin tick(); n++; if (cl_gnt[1] === 1'b1) found = 1'b1; end
        cl_req = '0; client_priority = '0;
        wait_idle(100);
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL starve_gnt: got no grant to client 1 want grant"); end
        vectors++; if (cyc - t0 < 255) begin miscompares++; $display("FAIL starve_wait: got %0d cycles want >=255", cyc - t0); end
        vectors++; if (starve_cnt - sb != 1 || starve_gnt !== 5'b00010) begin miscompares++; $display("FAIL starve_flag: got %0d pulses gnt=%b want 1 pulse with 00010", starve_cnt - sb, starve_gnt); end
    endtask
`endif

    initial begin
        client_priority = '0; cl_req = '0; cl_addr = '0; cl_len = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_outstanding();
        test_wrap();
        test_reset_mid();
`ifdef MANNIX_ARB_STARVE_EN
        test_starve();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mannix_mem_read_arb.md
Name: mannix_mem_read_arb

Overview:
- Read-port arbiter and burst sequencer in front of the mannix memory farm.
- Shares one memory read channel between NUM_CLIENTS read clients: fcc_pic, fcc_wgt, cnn_pic, cnn_wgt, pool (index 0..4).
- Selection is by a software priority mask, then round-robin; each grant is locked for a full burst.
- Issues one address per accepted beat and routes returned data back to the granted client.

Parameters:
- NUM_CLIENTS, 5: number of read requesters.
- ADDR_W, 32: address width.
- DATA_W, 32: data word width.
- LEN_W, 8: burst length field width; a length of 0 means 1 beat.
- MAX_OUTSTANDING, 4: maximum addresses issued but not yet returned.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous reset, active-high.
- client_priority, input, NUM_CLIENTS: 1 marks a client as high-priority class.
- cl_req, input, NUM_CLIENTS: per-client burst request; held until cl_gnt.
- cl_addr, input, NUM_CLIENTS*ADDR_W: per-client burst start address.
- cl_len, input, NUM_CLIENTS*LEN_W: per-client beats minus 1.
- cl_gnt, output, NUM_CLIENTS: one-hot, 1-cycle pulse when a burst is accepted.
- cl_rvalid, output, NUM_CLIENTS: one-hot; read data valid for that client.
- cl_rlast, output, 1: last beat of the current burst.
- cl_rdata, output, DATA_W: shared read-data bus.
- mem_req, output, 1: memory read address valid.
- mem_addr, output, ADDR_W: memory word address.
- mem_ready, input, 1: memory accepts mem_req this cycle.
- mem_rvalid, input, 1: in-order read data return.
- mem_rdata, input, DATA_W: read data.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset values: cl_gnt=0, cl_rvalid=0, cl_rlast=0, cl_rdata=0, mem_req=0, mem_addr=0, busy=0, rr_ptr=0, outstanding=0, FSM=IDLE. Reset mid-burst aborts the burst; memory returns arriving after reset are dropped.
- IDLE → BURST:
  - Eligible set: cl_req & client_priority if that is nonzero, else cl_req.
  - Winner: first eligible client at or after rr_ptr, wrapping.
  - Registered outputs: cl_gnt[w] pulses for 1 cycle.
  - Latched: addr, beats=len+1, owner=w.
  - rr_ptr ← (w+1) mod NUM_CLIENTS.
  - Latency from cl_req to cl_gnt is 1 cycle.
- BURST:
  - mem_req=1 while issued<beats and outstanding<MAX_OUTSTANDING.
  - On mem_req&&mem_ready: mem_addr+=1, issued+=1, outstanding+=1.
  - Transition to DRAIN after the final beat is accepted.
- DRAIN: mem_req=0; transition to IDLE once all beats have returned.
- Return path (valid in BURST and DRAIN):
  - On mem_rvalid: cl_rvalid[owner]=1 and cl_rdata=mem_rdata, registered (1-cycle latency); outstanding-=1; returned+=1.
  - cl_rlast=1 on returned==beats-1.
  - Simultaneous issue and return in one cycle leaves outstanding unchanged.
- mem_rvalid arriving in IDLE is a protocol error and is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- len=2^LEN_W-1 gives 2^LEN_W beats; issued/returned counters are LEN_W+1 bits.
- cl_req dropped after grant has no effect; a new cl_req from the owner is arbitrated only after IDLE is re-entered.
- IDLE with no requests: outputs stay 0 and rr_ptr is unchanged.
- client_priority is sampled only in IDLE; changes during a burst take effect at the next arbitration.
- busy=1 in BURST and DRAIN.

Optional Feature:
- Macro: MANNIX_ARB_STARVE_EN.
- When defined:
  - A per-client wait counter (8 bits) counts cycles with cl_req=1 and not granted.
  - When a counter reaches 255, that client overrides both the priority mask and round-robin; lowest index wins if several starve.
  - A client's counter clears on its grant.
  - Output starve_flag (1 bit) pulses on any such override.
- When undefined: no counters; the starve_flag port is absent.

Test Plan:
- Single client 2, addr=0x100, len=3, mem_ready=1, 2-cycle memory → cl_gnt[2] 1 cycle after req; mem_addr 0x100..0x103; 4 cl_rvalid[2] beats; cl_rlast on the 4th; busy drops after.
- Clients 0,1,3 request continuously, client_priority=0 → grant order 0,1,3,0,1,3.
- client_priority=5'b10000 with all 5 requesting → client 4 wins every arbitration until cl_req[4]=0, then round-robin resumes among 0..3.
- mem_ready toggling 1/0, memory latency 6, MAX_OUTSTANDING=4, len=15 → never more than 4 in flight; 16 returns in order; rlast on beat 16.
- addr=0xFFFFFFFE, len=3 → mem_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted mid-BURST after 2 of 8 beats → next cycle all outputs 0 and FSM IDLE; a late mem_rvalid produces no cl_rvalid. With MANNIX_ARB_STARVE_EN, client 1 low-priority against a permanently requesting high-priority client 0 → client 1 granted once its wait reaches 255; starve_flag pulses.
